// File: rtl/uart_rx_cfg.sv
// UART receiver with configurable data bits, oversampling, parity and stop bits.
// Ports: clk, reset_n, s_tick, rx, rx_ready in; rx_valid, rx_data, parity_err, frame_err, overrun out.
module uart_rx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 s_tick,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] PAR   = 3'd3;
  localparam logic [2:0] STOP  = 3'd4;
  localparam logic [2:0] BRK   = 3'd5;

  logic                 meta_q;
  logic                 rxs_q;
  logic [2:0]           state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 done_q, done_d;
  logic                 valid_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 pe_q;
  logic                 fe_q;
  logic                 ovr_q;

  logic                 sample;
  logic                 par_x;
  logic                 ferr_now;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b1;
      rxs_q  <= 1'b1;
    end else begin
      meta_q <= rx;
      rxs_q  <= meta_q;
    end
  end

  // A bit is sampled at the end of each full bit period,
  // which lands mid-bit because START stops at half a period.
  assign sample = s_tick && (tick_q == TICK_END);
  assign par_x  = (^shift_q) ^ rxs_q;

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    done_d   = 1'b0;
    ferr_now = ferr_q | ~rxs_q;
    unique case (state_q)
      IDLE: begin
        if (!rxs_q) begin
          state_d = START;
          tick_d  = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (tick_q == TICK_MID) begin
            if (!rxs_q) begin
              state_d = DATA;
              tick_d  = '0;
              bit_d   = '0;
              perr_d  = 1'b0;
              ferr_d  = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      DATA: begin
        if (sample) begin
          tick_d  = '0;
          shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? PAR : STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else if (s_tick) begin
          tick_d = tick_q + TW'(1);
        end
      end
      PAR: begin
        if (sample) begin
          tick_d  = '0;
          bit_d   = '0;
          perr_d  = (PARITY == 2) ? ~par_x : par_x;
          state_d = STOP;
        end else if (s_tick) begin
          tick_d = tick_q + TW'(1);
        end
      end
      STOP: begin
        if (sample) begin
          tick_d = '0;
          ferr_d = ferr_now;
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            done_d  = 1'b1;
            state_d = ferr_now ? BRK : IDLE;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else if (s_tick) begin
          tick_d = tick_q + TW'(1);
        end
      end
      BRK: begin
        // Hold off a new start until the line returns high.
        if (rxs_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      done_q  <= done_d;
    end
  end

  // Frame results are stable in shift/perr/ferr for the cycle
  // after completion; the next frame needs many ticks to disturb them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (done_q) begin
        if (!valid_q || rx_ready) begin
          valid_q <= 1'b1;
          data_q  <= shift_q;
          pe_q    <= perr_q;
          fe_q    <= ferr_q;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (valid_q && rx_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx_valid   = valid_q;
  assign rx_data    = data_q;
  assign parity_err = pe_q;
  assign frame_err  = fe_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: four configurations driven with directed frames.
// Table vectors for single frames plus sequences for break, glitch, overrun, reset.
module tb_uart_rx_cfg;

  localparam int BITCLK = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic s_tick = 1'b0;
  logic rx_l [4];
  logic rdy [4];
  logic rv [4];
  logic pe [4];
  logic fe [4];
  logic ov [4];
  logic [7:0] rd0, rd1, rd2;
  logic [6:0] rd3;
  logic [8:0] rdw [4];

  int nb [4] = '{8, 8, 8, 7};
  int pm [4] = '{0, 1, 1, 0};
  int ns [4] = '{1, 1, 1, 2};

  int rises [4];
  int vcyc [4];
  int ovc [4];
  logic rvp [4];
  logic [8:0] lastd [4];
  logic lastpe [4];
  logic lastfe [4];

  int total = 0;
  int pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) s_tick <= ~s_tick;

  assign rdw[0] = {1'b0, rd0};
  assign rdw[1] = {1'b0, rd1};
  assign rdw[2] = {1'b0, rd2};
  assign rdw[3] = {2'b0, rd3};

  uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .rx(rx_l[0]),
    .rx_ready(rdy[0]), .rx_valid(rv[0]), .rx_data(rd0),
    .parity_err(pe[0]), .frame_err(fe[0]), .overrun(ov[0]));

  uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(1), .STOP_BITS(1)) u1 (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .rx(rx_l[1]),
    .rx_ready(rdy[1]), .rx_valid(rv[1]), .rx_data(rd1),
    .parity_err(pe[1]), .frame_err(fe[1]), .overrun(ov[1]));

  uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(2), .STOP_BITS(1)) u2 (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .rx(rx_l[2]),
    .rx_ready(rdy[2]), .rx_valid(rv[2]), .rx_data(rd2),
    .parity_err(pe[2]), .frame_err(fe[2]), .overrun(ov[2]));

  uart_rx_cfg #(.DATA_BITS(7), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(2)) u3 (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .rx(rx_l[3]),
    .rx_ready(rdy[3]), .rx_valid(rv[3]), .rx_data(rd3),
    .parity_err(pe[3]), .frame_err(fe[3]), .overrun(ov[3]));

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rv[i] && !rvp[i]) begin
        rises[i]  <= rises[i] + 1;
        lastd[i]  <= rdw[i];
        lastpe[i] <= pe[i];
        lastfe[i] <= fe[i];
      end
      if (rv[i]) vcyc[i] <= vcyc[i] + 1;
      if (ov[i]) ovc[i] <= ovc[i] + 1;
      rvp[i] <= rv[i];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    else
      pass++;
  endtask

  task automatic bit_out(input int k, input logic v);
    rx_l[k] = v;
    repeat (BITCLK) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    repeat (n * BITCLK) @(negedge clk);
  endtask

  task automatic send_frame(input int k, input logic [8:0] d,
                            input logic pb, input logic [1:0] stp);
    bit_out(k, 1'b0);
    for (int i = 0; i < nb[k]; i++) bit_out(k, d[i]);
    if (pm[k] != 0) bit_out(k, pb);
    for (int i = 0; i < ns[k]; i++) bit_out(k, stp[i]);
    rx_l[k] = 1'b1;
  endtask

  typedef struct {
    int         k;
    logic [8:0] d;
    logic       pb;
    logic [1:0] stp;
    logic [8:0] ed;
    logic       epe;
    logic       efe;
  } vec_t;

  vec_t tv [11];

  initial begin
    int r0, c0, o0;
    tv[0]  = '{0, 9'h0A5, 1'b0, 2'b11, 9'h0A5, 1'b0, 1'b0};
    tv[1]  = '{0, 9'h000, 1'b0, 2'b11, 9'h000, 1'b0, 1'b0};
    tv[2]  = '{0, 9'h0FF, 1'b0, 2'b11, 9'h0FF, 1'b0, 1'b0};
    tv[3]  = '{1, 9'h03C, 1'b1, 2'b11, 9'h03C, 1'b1, 1'b0};
    tv[4]  = '{2, 9'h03C, 1'b1, 2'b11, 9'h03C, 1'b0, 1'b0};
    tv[5]  = '{1, 9'h03C, 1'b0, 2'b11, 9'h03C, 1'b0, 1'b0};
    tv[6]  = '{2, 9'h03C, 1'b0, 2'b11, 9'h03C, 1'b1, 1'b0};
    tv[7]  = '{1, 9'h001, 1'b1, 2'b11, 9'h001, 1'b0, 1'b0};
    tv[8]  = '{3, 9'h05A, 1'b0, 2'b11, 9'h05A, 1'b0, 1'b0};
    tv[9]  = '{0, 9'h081, 1'b0, 2'b00, 9'h081, 1'b0, 1'b1};
    tv[10] = '{3, 9'h02B, 1'b0, 2'b01, 9'h02B, 1'b0, 1'b1};

    for (int i = 0; i < 4; i++) begin
      rx_l[i] = 1'b1;
      rdy[i]  = 1'b1;
      rises[i] = 0;
      vcyc[i]  = 0;
      ovc[i]   = 0;
      rvp[i]   = 1'b0;
      lastd[i] = '0;
      lastpe[i] = 1'b0;
      lastfe[i] = 1'b0;
    end

    reset_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++)
      chk($sformatf("reset_outs%0d", i),
          {rv[i], rdw[i], pe[i], fe[i], ov[i]}, 32'h0);
    reset_n = 1'b1;
    idle_bits(1);

    for (int v = 0; v < 11; v++) begin
      r0 = rises[tv[v].k];
      c0 = vcyc[tv[v].k];
      send_frame(tv[v].k, tv[v].d, tv[v].pb, tv[v].stp);
      idle_bits(2);
      chk($sformatf("vec%0d_frames", v), rises[tv[v].k] - r0, 1);
      chk($sformatf("vec%0d_vcycles", v), vcyc[tv[v].k] - c0, 1);
      chk($sformatf("vec%0d_data", v), lastd[tv[v].k], tv[v].ed);
      chk($sformatf("vec%0d_perr", v), lastpe[tv[v].k], tv[v].epe);
      chk($sformatf("vec%0d_ferr", v), lastfe[tv[v].k], tv[v].efe);
    end

    // break: zero data, zero stop, line held low 20 bit times
    r0 = rises[0];
    for (int i = 0; i < 10; i++) bit_out(0, 1'b0);
    repeat (20) bit_out(0, 1'b0);
    chk("brk_frames", rises[0] - r0, 1);
    chk("brk_ferr", lastfe[0], 1);
    chk("brk_data", lastd[0], 0);
    rx_l[0] = 1'b1;
    idle_bits(2);
    chk("brk_quiet", rises[0] - r0, 1);
    send_frame(0, 9'h0A5, 1'b0, 2'b11);
    idle_bits(2);
    chk("brk_next_frames", rises[0] - r0, 2);
    chk("brk_next_data", lastd[0], 9'h0A5);
    chk("brk_next_ferr", lastfe[0], 0);

    // start glitch: 4 ticks low
    r0 = rises[0];
    rx_l[0] = 1'b0;
    repeat (8) @(negedge clk);
    rx_l[0] = 1'b1;
    idle_bits(2);
    chk("glitch_nofr", rises[0] - r0, 0);
    send_frame(0, 9'h03C, 1'b0, 2'b11);
    idle_bits(2);
    chk("glitch_next", rises[0] - r0, 1);
    chk("glitch_data", lastd[0], 9'h03C);

    // overrun
    r0 = rises[0];
    o0 = ovc[0];
    rdy[0] = 1'b0;
    send_frame(0, 9'h011, 1'b0, 2'b11);
    idle_bits(2);
    send_frame(0, 9'h022, 1'b0, 2'b11);
    idle_bits(2);
    chk("ovr_valid", rv[0], 1);
    chk("ovr_data", rdw[0], 9'h011);
    chk("ovr_frames", rises[0] - r0, 1);
    chk("ovr_pulse", ovc[0] - o0, 1);
    chk("ovr_now", ov[0], 0);
    rdy[0] = 1'b1;
    @(negedge clk);
    chk("ovr_accept", rv[0], 0);

    // reset mid-DATA on the 7-bit, 2-stop instance
    rdy[3] = 1'b0;
    send_frame(3, 9'h033, 1'b0, 2'b11);
    idle_bits(2);
    chk("rst_held", rdw[3], 9'h033);
    bit_out(3, 1'b0);
    for (int i = 0; i < 3; i++) bit_out(3, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("rst_outs", {rv[3], rdw[3], pe[3], fe[3], ov[3]}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    r0 = rises[3];
    bit_out(3, 1'b1);
    bit_out(3, 1'b1);
    bit_out(3, 1'b1);
    bit_out(3, 1'b1);
    idle_bits(2);
    chk("rst_abort", rises[3] - r0, 0);
    rdy[3] = 1'b1;
    send_frame(3, 9'h05A, 1'b0, 2'b11);
    idle_bits(2);
    chk("rst_next_frames", rises[3] - r0, 1);
    chk("rst_next_data", lastd[3], 9'h05A);
    chk("rst_next_err", {lastpe[3], lastfe[3]}, 0);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 Parameter: DATA_BITS, 8, data bits per frame, legal range 5..9.
REQ-002 Parameter: OVERSAMPLE, 16, s_tick pulses per bit period, even, >= 8.
REQ-003 Parameter: PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
REQ-004 Parameter: STOP_BITS, 1, stop bits checked per frame, 1 or 2.
REQ-005 Port: clk  input  1  clock; reset reset_n, asynchronous, active-low; clock clk.
REQ-006 Port: reset_n  input  1  asynchronous active-low reset.
REQ-007 Port: s_tick  input  1  oversample enable, one-clk pulse, OVERSAMPLE pulses per bit.
REQ-008 Port: rx  input  1  asynchronous serial line, idle high, LSB first.
REQ-009 Port: rx_ready  input  1  consumer accepts the held frame when high with rx_valid.
REQ-010 Port: rx_valid  output  1  held frame available.
REQ-011 Port: rx_data  output  DATA_BITS  received data word.
REQ-012 Port: parity_err  output  1  parity mismatch for held frame; 0 when PARITY=0.
REQ-013 Port: frame_err  output  1  any checked stop bit sampled 0 for held frame.
REQ-014 Port: overrun  output  1  one-clk pulse when a completed frame is dropped.

Function
REQ-015 The block SHALL pass rx through a 2-flop synchronizer (reset value 1); all sampling SHALL use the synchronized signal rxs.
REQ-016 The FSM SHALL use states IDLE, START, DATA, PAR, STOP, BRK; tick counter width $clog2(OVERSAMPLE), bit counter width $clog2(DATA_BITS+1).
REQ-017 IDLE: on any clk with rxs==0 -> START, tick counter cleared; no s_tick required.
REQ-018 START: count s_tick; on the tick where counter==OVERSAMPLE/2-1: rxs==0 -> DATA (counters cleared), rxs==1 -> IDLE (glitch rejected, no outputs change).
REQ-019 DATA/PAR/STOP: each bit sampled on the s_tick where counter==OVERSAMPLE-1, counter then cleared; otherwise counter increments on s_tick only.
REQ-020 DATA: samples SHALL shift in from the MSB side (right shift) so bit 0 lands at rx_data[0]; after DATA_BITS samples -> PAR if PARITY!=0, else STOP.
REQ-021 PAR: parity_err = (XOR of data bits ^ sampled bit) != 0 for even, == 0 for odd.
REQ-022 STOP: STOP_BITS samples; any 0 sets frame_err for the frame; on the last stop sample the frame completes.
REQ-023 Completion with frame_err=0 -> IDLE; with frame_err=1 -> BRK; BRK -> IDLE only when rxs==1.
REQ-024 On completion, the next clk edge SHALL load rx_data, parity_err, frame_err and set rx_valid=1 (latency: 1 clk after the final stop-bit s_tick).
REQ-025 rx_valid && rx_ready on a clk edge SHALL clear rx_valid unless a new frame loads on the same edge.
REQ-026 Completion while rx_valid=1 and rx_ready=0: new frame discarded, held outputs unchanged, overrun=1 for exactly one clk.
REQ-027 Completion while rx_valid=1 and rx_ready=1: new frame loaded, rx_valid stays 1, no overrun.
REQ-028 Outputs SHALL be stable while rx_valid=1 and not accepted.

Reset
REQ-029 reset_n low SHALL force state IDLE, counters and shift register 0, synchronizer 1, rx_valid/rx_data/parity_err/frame_err/overrun 0, immediately and asynchronously.
REQ-030 Reset mid-frame SHALL abort the frame with no output; reception resumes on the next falling edge of rxs after release.

Verification
REQ-031 Defaults, rx_ready=1, send 0xA5 -> rx_valid 1 clk, rx_data=0xA5, parity_err=0, frame_err=0.
REQ-032 PARITY=1, send 0x3C with parity bit 1 -> rx_data=0x3C, parity_err=1; PARITY=2 same stimulus -> parity_err=0.
REQ-033 Stop bit 0 then rx held low 20 bit times -> exactly one frame, frame_err=1, data 0x00 if break; no further frame until rx high then new start.
REQ-034 rx low for 4 s_ticks then high -> no rx_valid, FSM back in IDLE.
REQ-035 rx_ready=0, frames 0x11 then 0x22 -> rx_data=0x11 held, overrun one pulse; rx_ready=1 -> rx_valid clears next edge.
REQ-036 reset_n pulsed low mid-DATA -> all outputs 0; next frame 0x5A with DATA_BITS=7, STOP_BITS=2 received as 0x5A, no errors.
